// File: rtl/i281_pkg.sv
// Shared constants for the i281 decoder: opcode and sub-op encodings, and the
// bit index of each op_bus line.
package i281_pkg;

  localparam int OP_BUS_W = 23;

  localparam logic [3:0] OPC_NOOP    = 4'h0;
  localparam logic [3:0] OPC_INPUT   = 4'h1;
  localparam logic [3:0] OPC_MOVE    = 4'h2;
  localparam logic [3:0] OPC_LOADI   = 4'h3;
  localparam logic [3:0] OPC_ADD     = 4'h4;
  localparam logic [3:0] OPC_ADDI    = 4'h5;
  localparam logic [3:0] OPC_SUB     = 4'h6;
  localparam logic [3:0] OPC_SUBI    = 4'h7;
  localparam logic [3:0] OPC_LOAD    = 4'h8;
  localparam logic [3:0] OPC_LOADF   = 4'h9;
  localparam logic [3:0] OPC_STORE   = 4'hA;
  localparam logic [3:0] OPC_STOREF  = 4'hB;
  localparam logic [3:0] OPC_SHIFT   = 4'hC;
  localparam logic [3:0] OPC_CMP     = 4'hD;
  localparam logic [3:0] OPC_JUMP    = 4'hE;
  localparam logic [3:0] OPC_BRANCH  = 4'hF;

  localparam logic [1:0] SUB_INPUT_DATAC  = 2'b00;
  localparam logic [1:0] SUB_INPUT_DATACF = 2'b01;
  localparam logic [1:0] SUB_INPUT_DATAD  = 2'b10;
  localparam logic [1:0] SUB_INPUT_DATADF = 2'b11;
  localparam logic       SUB_SHIFTR       = 1'b1;
  localparam logic [1:0] SUB_BRE_BRZ      = 2'b00;
  localparam logic [1:0] SUB_BRNE_BRNZ    = 2'b01;
  localparam logic [1:0] SUB_BRG          = 2'b10;
  localparam logic [1:0] SUB_BRGE         = 2'b11;

  localparam int B_NOOP          = 0;
  localparam int B_INPUT_DATAC   = 1;
  localparam int B_INPUT_DATACF  = 2;
  localparam int B_INPUT_DATAD   = 3;
  localparam int B_INPUT_DATADF  = 4;
  localparam int B_MOVE          = 5;
  localparam int B_LOADI_LOADP   = 6;
  localparam int B_ADD           = 7;
  localparam int B_ADDI          = 8;
  localparam int B_SUB           = 9;
  localparam int B_SUBI          = 10;
  localparam int B_LOAD          = 11;
  localparam int B_LOADF         = 12;
  localparam int B_STORE         = 13;
  localparam int B_STOREF        = 14;
  localparam int B_SHIFTL        = 15;
  localparam int B_SHIFTR        = 16;
  localparam int B_CMP           = 17;
  localparam int B_JUMP          = 18;
  localparam int B_BRE_BRZ       = 19;
  localparam int B_BRNE_BRNZ     = 20;
  localparam int B_BRG           = 21;
  localparam int B_BRGE          = 22;

  function automatic logic [OP_BUS_W-1:0] op_bit(input int idx);
    return OP_BUS_W'(1) << idx;
  endfunction

endpackage

// File: rtl/i281_opcode_onehot.sv
// Pure combinational decode of opcode + sub-op bits into the one-hot op_bus.
module i281_opcode_onehot
  import i281_pkg::*;
(
  input  logic [3:0]          opcode,
  input  logic [1:0]          sub_op,
  output logic [OP_BUS_W-1:0] op_bus
);

  always_comb begin
    op_bus = '0;
    case (opcode)
      OPC_NOOP:   op_bus = op_bit(B_NOOP);
      OPC_INPUT: begin
        case (sub_op)
          SUB_INPUT_DATAC:  op_bus = op_bit(B_INPUT_DATAC);
          SUB_INPUT_DATACF: op_bus = op_bit(B_INPUT_DATACF);
          SUB_INPUT_DATAD:  op_bus = op_bit(B_INPUT_DATAD);
          SUB_INPUT_DATADF: op_bus = op_bit(B_INPUT_DATADF);
          default:          op_bus = '0;
        endcase
      end
      OPC_MOVE:   op_bus = op_bit(B_MOVE);
      OPC_LOADI:  op_bus = op_bit(B_LOADI_LOADP);
      OPC_ADD:    op_bus = op_bit(B_ADD);
      OPC_ADDI:   op_bus = op_bit(B_ADDI);
      OPC_SUB:    op_bus = op_bit(B_SUB);
      OPC_SUBI:   op_bus = op_bit(B_SUBI);
      OPC_LOAD:   op_bus = op_bit(B_LOAD);
      OPC_LOADF:  op_bus = op_bit(B_LOADF);
      OPC_STORE:  op_bus = op_bit(B_STORE);
      OPC_STOREF: op_bus = op_bit(B_STOREF);
      // Only bit 8 distinguishes the shift direction; bit 9 is don't-care.
      OPC_SHIFT:  op_bus = (sub_op[0] == SUB_SHIFTR) ? op_bit(B_SHIFTR) : op_bit(B_SHIFTL);
      OPC_CMP:    op_bus = op_bit(B_CMP);
      OPC_JUMP:   op_bus = op_bit(B_JUMP);
      OPC_BRANCH: begin
        case (sub_op)
          SUB_BRE_BRZ:   op_bus = op_bit(B_BRE_BRZ);
          SUB_BRNE_BRNZ: op_bus = op_bit(B_BRNE_BRNZ);
          SUB_BRG:       op_bus = op_bit(B_BRG);
          SUB_BRGE:      op_bus = op_bit(B_BRGE);
          default:       op_bus = '0;
        endcase
      end
      default:    op_bus = '0;
    endcase
  end

endmodule

// File: rtl/i281_instr_decode_stage.sv
// One-entry registered decode stage with valid/ready handshake, flush and a
// hand-off counter. Optional jump-to-self halt detect under I281_HALT_DETECT_EN.
module i281_instr_decode_stage
  import i281_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = 16,
  parameter int CW = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IW-1:0]       instr_in,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  input  logic                flush,
  output logic [OP_BUS_W-1:0] op_bus,
  output logic [N-1:0]        x_sel,
  output logic [N-1:0]        y_sel,
  output logic [7:0]          imm,
`ifdef I281_HALT_DETECT_EN
  output logic                halted,
`endif
  output logic [CW-1:0]       instr_count
);

  localparam logic EMPTY = 1'b0;
  localparam logic FULL  = 1'b1;

  logic                state;
  logic [OP_BUS_W-1:0] op_dec;
  logic [OP_BUS_W-1:0] op_reg;
  logic [N-1:0]        x_reg;
  logic [N-1:0]        y_reg;
  logic [7:0]          imm_reg;
  logic                stall;
  logic                accept;
  logic                handoff;

  i281_opcode_onehot u_onehot (
    .opcode (instr_in[15:12]),
    .sub_op (instr_in[9:8]),
    .op_bus (op_dec)
  );

  assign out_valid = (state == FULL);
  assign in_ready  = (!out_valid || out_ready) && !stall;
  assign accept    = in_valid && in_ready && !flush;
  assign handoff   = out_valid && out_ready;

  // op_bus is masked so it reads all-zero whenever nothing valid is held.
  assign op_bus = out_valid ? op_reg : '0;
  assign x_sel  = x_reg;
  assign y_sel  = y_reg;
  assign imm    = imm_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= EMPTY;
      op_reg      <= '0;
      x_reg       <= '0;
      y_reg       <= '0;
      imm_reg     <= '0;
      instr_count <= '0;
    end else begin
      if (handoff) instr_count <= instr_count + 1'b1;
      // Flush wins over accept; a same-cycle hand-off above still counts.
      if (flush) begin
        state <= EMPTY;
      end else if (accept) begin
        state   <= FULL;
        op_reg  <= op_dec;
        x_reg   <= instr_in[10 +: N];
        y_reg   <= instr_in[8 +: N];
        imm_reg <= instr_in[7:0];
      end else if (handoff) begin
        state <= EMPTY;
      end
    end
  end

`ifdef I281_HALT_DETECT_EN
  assign stall = halted;

  // Sticky until reset once a JUMP to 0xFF (jump-to-self) is handed off.
  always_ff @(posedge clk) begin
    if (reset) halted <= 1'b0;
    else if (handoff && op_reg[B_JUMP] && imm_reg == 8'hFF) halted <= 1'b1;
  end
`else
  assign stall = 1'b0;
`endif

endmodule

// File: tb/tb_i281_instr_decode_stage.sv
// Scoreboard bench for i281_instr_decode_stage (CW=4 to exercise counter wrap).
// Also covers the halt-detect port when I281_HALT_DETECT_EN is defined.
module tb_i281_instr_decode_stage;

  typedef struct packed {
    logic [4:0] idx;
    logic [1:0] x;
    logic [1:0] y;
    logic [7:0] imm;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr_in;
  logic        in_valid;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic        flush;
  logic [22:0] op_bus;
  logic [1:0]  x_sel;
  logic [1:0]  y_sel;
  logic [7:0]  imm;
  logic [3:0]  instr_count;
`ifdef I281_HALT_DETECT_EN
  logic        halted;
`endif

  int   errors = 0;
  int   checks = 0;
  int   exp_count = 0;
  exp_t sb[$];

  i281_instr_decode_stage #(.N(2), .IW(16), .CW(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_in    (instr_in),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .flush       (flush),
    .op_bus      (op_bus),
    .x_sel       (x_sel),
    .y_sel       (y_sel),
    .imm         (imm),
`ifdef I281_HALT_DETECT_EN
    .halted      (halted),
`endif
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change at posedge+1; the accept decision is taken at the negedge.
  task automatic applyStimulus(input logic [15:0] w, input logic v, input logic ordy,
                               input logic fl, input exp_t e, output logic acc);
    instr_in  = w;
    in_valid  = v;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    acc = v && in_ready && !fl;
    if (acc) sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset    = 1'b1;
    in_valid = 1'b0;
    flush    = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every hand-off and tracks the count model.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      sb.delete();
      exp_count = 0;
    end else begin
      checkOutput("instr_count", 32'(instr_count), 32'(exp_count));
      if (out_valid) checkOutput("onehot", 32'($onehot(op_bus)), 32'd1);
      else           checkOutput("idle_op_bus", 32'(op_bus), 32'd0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_handoff: got op_bus %0h expected no output", op_bus);
        end else begin
          e = sb.pop_front();
          checkOutput("op_bus", 32'(op_bus), 32'(1) << e.idx);
          checkOutput("x_sel", 32'(x_sel), 32'(e.x));
          checkOutput("y_sel", 32'(y_sel), 32'(e.y));
          checkOutput("imm", 32'(imm), 32'(e.imm));
        end
        exp_count = (exp_count + 1) % 16;
      end
    end
  end

  initial begin
    logic acc;
    logic [15:0] vw [19];
    exp_t        ve [19];
    exp_t        none;
    none = '0;

    vw[0]  = 16'h4600; ve[0]  = '{5'd7,  2'd1, 2'd2, 8'h00};
    vw[1]  = 16'h1300; ve[1]  = '{5'd4,  2'd0, 2'd3, 8'h00};
    vw[2]  = 16'hC100; ve[2]  = '{5'd16, 2'd0, 2'd1, 8'h00};
    vw[3]  = 16'hF200; ve[3]  = '{5'd21, 2'd0, 2'd2, 8'h00};
    vw[4]  = 16'h3005; ve[4]  = '{5'd6,  2'd0, 2'd0, 8'h05};
    vw[5]  = 16'h0000; ve[5]  = '{5'd0,  2'd0, 2'd0, 8'h00};
    vw[6]  = 16'h2D00; ve[6]  = '{5'd5,  2'd3, 2'd1, 8'h00};
    vw[7]  = 16'hD000; ve[7]  = '{5'd17, 2'd0, 2'd0, 8'h00};
    vw[8]  = 16'h1000; ve[8]  = '{5'd1,  2'd0, 2'd0, 8'h00};
    vw[9]  = 16'h7AFF; ve[9]  = '{5'd10, 2'd2, 2'd2, 8'hFF};
    vw[10] = 16'hB400; ve[10] = '{5'd14, 2'd1, 2'd0, 8'h00};
    vw[11] = 16'hF300; ve[11] = '{5'd22, 2'd0, 2'd3, 8'h00};
    vw[12] = 16'h1100; ve[12] = '{5'd2,  2'd0, 2'd1, 8'h00};
    vw[13] = 16'h1200; ve[13] = '{5'd3,  2'd0, 2'd2, 8'h00};
    vw[14] = 16'hF000; ve[14] = '{5'd19, 2'd0, 2'd0, 8'h00};
    vw[15] = 16'hF100; ve[15] = '{5'd20, 2'd0, 2'd1, 8'h00};
    vw[16] = 16'hC200; ve[16] = '{5'd15, 2'd0, 2'd2, 8'h00};
    vw[17] = 16'h8C12; ve[17] = '{5'd11, 2'd3, 2'd0, 8'h12};
    vw[18] = 16'h9700; ve[18] = '{5'd12, 2'd1, 2'd3, 8'h00};

    instr_in  = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    reset     = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_op_bus", 32'(op_bus), 32'd0);
    checkOutput("rst_x_sel", 32'(x_sel), 32'd0);
    checkOutput("rst_y_sel", 32'(y_sel), 32'd0);
    checkOutput("rst_imm", 32'(imm), 32'd0);
    checkOutput("rst_count", 32'(instr_count), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef I281_HALT_DETECT_EN
    checkOutput("rst_halted", 32'(halted), 32'd0);
`endif

    // First word: one-cycle latency, count advances after hand-off.
    applyStimulus(vw[0], 1'b1, 1'b1, 1'b0, ve[0], acc);
    checkOutput("first_out_valid", 32'(out_valid), 32'd1);
    checkOutput("first_op_bus", 32'(op_bus), 32'h80);
    applyStimulus(16'h0, 1'b0, 1'b1, 1'b0, none, acc);
    checkOutput("first_count", 32'(instr_count), 32'd1);

    // Back-to-back sub-op coverage; every word must be accepted.
    for (int i = 1; i < 19; i++) begin
      applyStimulus(vw[i], 1'b1, 1'b1, 1'b0, ve[i], acc);
      checkOutput("stream_accept", 32'(acc), 32'd1);
    end
    applyStimulus(16'h0, 1'b0, 1'b1, 1'b0, none, acc);

    // Back-pressure: held word must stay stable while out_ready is low.
    applyStimulus(16'h5155, 1'b1, 1'b0, 1'b0, '{5'd8, 2'd0, 2'd1, 8'h55}, acc);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(16'h6A00, 1'b1, 1'b0, 1'b0, '{5'd9, 2'd2, 2'd2, 8'h00}, acc);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      checkOutput("bp_op_bus", 32'(op_bus), 32'h100);
      checkOutput("bp_imm", 32'(imm), 32'h55);
      checkOutput("bp_y_sel", 32'(y_sel), 32'd1);
    end
    applyStimulus(16'h6A00, 1'b1, 1'b1, 1'b0, '{5'd9, 2'd2, 2'd2, 8'h00}, acc);
    checkOutput("bp_release_accept", 32'(acc), 32'd1);
    applyStimulus(vw[4], 1'b1, 1'b1, 1'b0, ve[4], acc);
    checkOutput("bp_b2b_accept", 32'(acc), 32'd1);
    applyStimulus(16'h0, 1'b0, 1'b1, 1'b0, none, acc);
    applyStimulus(16'h0, 1'b0, 1'b1, 1'b0, none, acc);

    // Flush while FULL and stalled: held word discarded, new word dropped.
    applyStimulus(16'hA100, 1'b1, 1'b0, 1'b0, '{5'd13, 2'd0, 2'd1, 8'h00}, acc);
    applyStimulus(16'h4500, 1'b1, 1'b0, 1'b1, none, acc);
    void'(sb.pop_back());
    checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
    checkOutput("flush_op_bus", 32'(op_bus), 32'd0);
    applyStimulus(16'h0, 1'b0, 1'b1, 1'b0, none, acc);
    checkOutput("flush_stays_empty", 32'(out_valid), 32'd0);

    // Flush coinciding with a hand-off: the hand-off still counts.
    applyStimulus(16'hE012, 1'b1, 1'b1, 1'b0, '{5'd18, 2'd0, 2'd0, 8'h12}, acc);
    applyStimulus(16'h4500, 1'b1, 1'b1, 1'b1, none, acc);
    checkOutput("flush_ho_out_valid", 32'(out_valid), 32'd0);
    applyStimulus(16'h0, 1'b0, 1'b1, 1'b0, none, acc);

    // Jump-to-self.
    applyStimulus(16'hE0FF, 1'b1, 1'b1, 1'b0, '{5'd18, 2'd0, 2'd0, 8'hFF}, acc);
    applyStimulus(16'h0, 1'b0, 1'b1, 1'b0, none, acc);
`ifdef I281_HALT_DETECT_EN
    checkOutput("halted_set", 32'(halted), 32'd1);
    checkOutput("halted_in_ready", 32'(in_ready), 32'd0);
    applyStimulus(vw[0], 1'b1, 1'b1, 1'b0, ve[0], acc);
    checkOutput("halted_no_accept", 32'(acc), 32'd0);
    checkOutput("halted_out_valid", 32'(out_valid), 32'd0);
    checkOutput("halted_sticky", 32'(halted), 32'd1);
`else
    checkOutput("nohalt_in_ready", 32'(in_ready), 32'd1);
    applyStimulus(vw[0], 1'b1, 1'b1, 1'b0, ve[0], acc);
    checkOutput("nohalt_accept", 32'(acc), 32'd1);
    applyStimulus(16'h0, 1'b0, 1'b1, 1'b0, none, acc);
`endif
    doReset();
`ifdef I281_HALT_DETECT_EN
    checkOutput("halt_cleared", 32'(halted), 32'd0);
`endif
    checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Reset mid-transfer discards the held word.
    applyStimulus(vw[0], 1'b1, 1'b0, 1'b0, ve[0], acc);
    checkOutput("mid_held", 32'(out_valid), 32'd1);
    doReset();
    checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_count", 32'(instr_count), 32'd0);

    // 16 hand-offs wrap the 4-bit counter back to 0.
    for (int i = 0; i < 16; i++) begin
      logic [3:0] k;
      k = 4'(i);
      applyStimulus({4'h5, k[1:0], k[3:2], 4'h0, k}, 1'b1, 1'b1, 1'b0,
                    '{5'd8, k[1:0], k[3:2], {4'h0, k}}, acc);
      if (i == 15) checkOutput("wrap_pre_count", 32'(instr_count), 32'd15);
    end
    applyStimulus(16'h0, 1'b0, 1'b1, 1'b0, none, acc);
    checkOutput("wrap_count", 32'(instr_count), 32'd0);

    applyStimulus(16'h0, 1'b0, 1'b1, 1'b0, none, acc);
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
